eight_bit_comp_seq: RTL and testbench
=====================================

# eight_bit_comp_seq

Sequencer for the 8-bit magnitude comparison path on the lab board. It collects A and B as four nibbles from one 4-bit switch bank and a single push-button. It then compares them bit-serially, MSB first, one bit per clock, through a single `one_bit_comparator` whose result is fed back through registers. It replaces four asynchronous button-clocked load registers and eight chained comparator cells with one clocked FSM plus one comparator cell.

## Interface
- `DATA_W`, 8: operand width; must be a multiple of `NIB_W`.
- `NIB_W`, 4: width of the switch input and of each load step.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `pb`  in  1  load push-button, already debounced and synchronised; only a rising edge is used.
- `Y`  in  NIB_W  switch nibble sampled on a `pb` edge.
- `a_val`  out  DATA_W  operand A as loaded.
- `b_val`  out  DATA_W  operand B as loaded.
- `busy`  out  1  high during COMPARE.
- `valid`  out  1  high in DONE; qualifies `l`, `g`, `e`.
- `l`, `g`, `e`  out  1 each  A<B, A>B, A==B; exactly one is high while `valid` is high.
- `stage`  out  3  current state encoding, for the LEDs.

## Operation
- Edge detect:
  - `pb_q` holds the previous `pb`.
  - `pb_rise = pb & ~pb_q`.
  - A held button produces exactly one event.
- FSM states and transitions:
  - LD_A_LO (0): on `pb_rise`, `a_val[3:0] <= Y`, go to LD_A_HI.
  - LD_A_HI (1): on `pb_rise`, `a_val[7:4] <= Y`, go to LD_B_LO.
  - LD_B_LO (2): on `pb_rise`, `b_val[3:0] <= Y`, go to LD_B_HI.
  - LD_B_HI (3): on `pb_rise`, `b_val[7:4] <= Y`, go to COMPARE.
    - On the same edge: bit index `idx <= DATA_W-1`; running flags `{lr,gr,er} <= 0,0,1`.
  - COMPARE (4): each cycle, one comparator evaluates `a_val[idx]`, `b_val[idx]` with `{lr,gr,er}` as the incoming flags.
    - The result is registered back into `{lr,gr,er}` and `idx` decrements.
    - On the cycle that evaluates `idx==0`, go to DONE and copy the result onto `l`, `g`, `e`.
  - DONE (5): `valid=1`, and `l`, `g`, `e` hold.
    - On `pb_rise`: `a_val[3:0] <= Y`, clear `valid` and `l`, `g`, `e`, go to LD_A_HI.
    - This means the next operation's first nibble is captured on the same press.
- `pb_rise` is ignored while in COMPARE.
- Operands are not modified after LD_B_HI until the next load cycle begins.
- Comparator semantics: once `lr` or `gr` is set it is sticky; lower bits cannot change it. `er` stays 1 only while all bits so far are equal.
- `idx` is `$clog2(DATA_W)` bits wide and never underflows; COMPARE exits at 0.

## Timing
- Reset values:
  - state LD_A_LO, `stage=0`.
  - `a_val=0`, `b_val=0`.
  - `busy=0`, `valid=0`.
  - `l=0`, `g=0`, `e=0`.
  - `pb_q=0`.
- Nibble capture occurs on the clock edge where `pb_rise` is sampled high; the value is visible on `a_val` or `b_val` in the next cycle.
- Compare latency: `DATA_W` cycles. `valid` rises `DATA_W` clocks after the edge that captured `b_val[7:4]`.
- `busy` is high for exactly those `DATA_W` cycles, and never overlaps `valid`.
- Reset in any state, including mid-COMPARE, takes effect at the next edge. No partial result is ever shown.
- Registered `{pb, Y}` and `rst` on the same edge: reset wins.

## Configuration
- `COMP_EARLY_EXIT_EN` defined:
  - COMPARE exits to DONE on the cycle whose evaluated bit first sets `lr` or `gr`.
  - Latency is k cycles, where k is the 1-based position of the first differing bit from the MSB.
  - Equal operands still take `DATA_W` cycles.
- Not defined: always `DATA_W` cycles, as above.
- Outputs at DONE are identical in both builds.

## Structure
- `eight_bit_comp_pkg` holds:
  - the state enum and its 3-bit encodings (0-5);
  - `DATA_W`/`NIB_W` defaults;
  - `IDX_W = $clog2(DATA_W)`.
- One sub-module: the existing `one_bit_comparator`, instantiated once (ports A bit, B bit, l/g/e in, l/g/e out). All iteration lives in the FSM.

## Test plan
- Load A=0x3C, B=0x3A.
  - Default build: `g=1`, `l=0`, `e=0`, `valid` 8 cycles after the 4th press.
  - Early-exit build: `valid` after 6 cycles.
- A=0xA5, B=0xA5: `e=1` after 8 cycles in both builds; `busy` high exactly 8 cycles.
- A=0x80, B=0x7F: `g=1`. A=0x00, B=0xFF: `l=1`. Early-exit build: both finish in 1 cycle.
- Hold `pb` high for 20 cycles in LD_A_LO: only `a_val[3:0]` loads, state advances to 1 only.
- Press `pb` twice during COMPARE: no operand or state change; the result matches the loaded operands.
- Assert `rst` at COMPARE cycle 3, then load A=0x01, B=0x02: all outputs return to reset values, then `l=1` at the proper latency.

Source files
------------

// File: rtl/eight_bit_comp_pkg.sv
// Shared types and defaults for the bit-serial 8-bit comparator sequencer.
package eight_bit_comp_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NIB_W  = 4;
  localparam int IDX_W      = $clog2(DEF_DATA_W);

  typedef enum logic [2:0] {
    LD_A_LO = 3'd0,
    LD_A_HI = 3'd1,
    LD_B_LO = 3'd2,
    LD_B_HI = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/one_bit_comparator.sv
// Single magnitude-compare cell; l/g are sticky, e survives only
// while every more-significant bit has matched.
module one_bit_comparator (
  input  logic a,
  input  logic b,
  input  logic l_in,
  input  logic g_in,
  input  logic e_in,
  output logic l_out,
  output logic g_out,
  output logic e_out
);

  assign l_out = l_in | (e_in & ~a & b);
  assign g_out = g_in | (e_in & a & ~b);
  assign e_out = e_in & ~(a ^ b);

endmodule

// File: rtl/eight_bit_comp_seq.sv
// Nibble-load sequencer with MSB-first bit-serial compare.
// Define COMP_EARLY_EXIT_EN to leave COMPARE on the first differing bit.
module eight_bit_comp_seq
  import eight_bit_comp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NIB_W  = DEF_NIB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pb,
  input  logic [NIB_W-1:0]  Y,
  output logic [DATA_W-1:0] a_val,
  output logic [DATA_W-1:0] b_val,
  output logic              busy,
  output logic              valid,
  output logic              l,
  output logic              g,
  output logic              e,
  output logic [2:0]        stage
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_W - 1);

  state_t        state;
  logic          pb_q;
  logic          pb_rise;
  logic [IW-1:0] idx;
  logic          lr, gr, er;
  logic          lc, gc, ec;
  logic          fin;

  assign pb_rise = pb & ~pb_q;

  one_bit_comparator u_cmp (
    .a     (a_val[idx]),
    .b     (b_val[idx]),
    .l_in  (lr),
    .g_in  (gr),
    .e_in  (er),
    .l_out (lc),
    .g_out (gc),
    .e_out (ec)
  );

`ifdef COMP_EARLY_EXIT_EN
  assign fin = (idx == '0) | lc | gc;
`else
  assign fin = (idx == '0);
`endif

  assign stage = state;
  assign busy  = (state == COMPARE);
  assign valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_A_LO;
      pb_q  <= 1'b0;
      a_val <= '0;
      b_val <= '0;
      idx   <= '0;
      lr    <= 1'b0;
      gr    <= 1'b0;
      er    <= 1'b1;
      l     <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
    end else begin
      pb_q <= pb;
      unique case (state)
        LD_A_LO: if (pb_rise) begin
          a_val[NIB_W-1:0] <= Y;
          state            <= LD_A_HI;
        end
        LD_A_HI: if (pb_rise) begin
          a_val[2*NIB_W-1:NIB_W] <= Y;
          state                  <= LD_B_LO;
        end
        LD_B_LO: if (pb_rise) begin
          b_val[NIB_W-1:0] <= Y;
          state            <= LD_B_HI;
        end
        LD_B_HI: if (pb_rise) begin
          b_val[2*NIB_W-1:NIB_W] <= Y;
          idx                    <= IDX_TOP;
          {lr, gr, er}           <= 3'b001;
          state                  <= COMPARE;
        end
        COMPARE: begin
          {lr, gr, er} <= {lc, gc, ec};
          if (fin) begin
            {l, g, e} <= {lc, gc, ec};
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: if (pb_rise) begin
          // This press also carries the next operation's first nibble
          a_val[NIB_W-1:0] <= Y;
          {l, g, e}        <= 3'b000;
          state            <= LD_A_HI;
        end
        default: state <= LD_A_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_comp_seq.sv
// Directed + random bench for eight_bit_comp_seq against an arithmetic model.
module tb_eight_bit_comp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pb;
  logic [3:0] Y;
  logic [7:0] a_val;
  logic [7:0] b_val;
  logic       busy;
  logic       valid;
  logic       l;
  logic       g;
  logic       e;
  logic [2:0] stage;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eight_bit_comp_seq dut (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb),
    .Y     (Y),
    .a_val (a_val),
    .b_val (b_val),
    .busy  (busy),
    .valid (valid),
    .l     (l),
    .g     (g),
    .e     (e),
    .stage (stage)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the last load press until DONE
  function automatic int lat(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
`ifdef COMP_EARLY_EXIT_EN
    for (int i = 7; i >= 0; i--)
      if (x[i]) return 8 - i;
`endif
    if (x == 8'h00) return 8;
    return 8;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_stage", stage, 0);
    chk("rst_a", a_val, 0);
    chk("rst_b", b_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_lge", {l, g, e}, 0);
  endtask

  task automatic press(input logic [3:0] nib, input int exp_stage,
                       input bit release_tick);
    Y  = nib;
    pb = 1'b1;
    tick();
    pb = 1'b0;
    chk("stage_press", stage, exp_stage);
    if (release_tick) tick();
  endtask

  // mode 0: plain, 1: presses during compare, 2: reset at cycle 3
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit skip_first, input int mode);
    int cyc;
    if (!skip_first) press(a[3:0], 1, 1'b1);
    chk("a_lo", a_val[3:0], a[3:0]);
    press(a[7:4], 2, 1'b1);
    chk("a_val", a_val, a);
    press(b[3:0], 3, 1'b1);
    press(b[7:4], 4, 1'b0);
    chk("b_val", b_val, b);
    cyc = 0;
    while (!valid && cyc < 40) begin
      chk("busy_hi", busy, 1);
      if (mode == 2 && cyc == 3) begin
        rst = 1'b1;
        pb  = 1'b1;
        Y   = 4'hF;
        tick();
        rst = 1'b0;
        pb  = 1'b0;
        chk_reset_vals();
        return;
      end
      if (mode == 1) begin
        pb = (cyc == 2 || cyc == 4);
        Y  = ~a[3:0];
      end
      tick();
      cyc++;
    end
    pb = 1'b0;
    chk("latency", cyc, lat(a, b));
    chk("valid", valid, 1);
    chk("busy_lo", busy, 0);
    chk("stage_done", stage, 5);
    chk("l", l, a < b);
    chk("g", g, a > b);
    chk("e", e, a == b);
    chk("a_hold", a_val, a);
    chk("b_hold", b_val, b);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst = 1'b1;
    pb  = 1'b0;
    Y   = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals();

    // Held button: one event only
    Y  = 4'hC;
    pb = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_stage", stage, 1);
    chk("hold_a", a_val, 8'h0C);
    pb = 1'b0;
    tick();
    run_op(8'h3C, 8'h3A, 1'b1, 0);

    run_op(8'hA5, 8'hA5, 1'b0, 0);
    run_op(8'h80, 8'h7F, 1'b0, 0);
    run_op(8'h00, 8'hFF, 1'b0, 0);
    run_op(8'h5A, 8'h5A, 1'b0, 1);
    run_op(8'h3C, 8'h3A, 1'b0, 2);
    run_op(8'h01, 8'h02, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
